instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset, with all state updated on the rising edge of clk.
REQ-002 The port clk (input, 1 bit) SHALL be the system clock.
REQ-003 The port reset (input, 1 bit) SHALL be the synchronous, active-high reset.
REQ-004 The port start (input, 1 bit) SHALL begin a program load at imem address 0.
REQ-005 The port in_valid (input, 1 bit) SHALL indicate that the instruction fields are valid.
REQ-006 The port in_kind (input, 3 bits) SHALL select the instruction: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 illegal.
REQ-007 The port rd_rt (input, 5 bits) SHALL carry Rd for R-format and Rt for D-format and CB-format.
REQ-008 The port rn (input, 5 bits) SHALL carry Rn.
REQ-009 The port rm (input, 5 bits) SHALL carry Rm, used by R-format only.
REQ-010 The port imm (input, 19 bits) SHALL carry the immediate: [8:0] is DT_address for LDUR/STUR, [18:0] is COND_BR_address for CBZ.
REQ-011 The port last (input, 1 bit) SHALL mark the final instruction of the program.
REQ-012 The port in_ready (output, 1 bit) SHALL indicate that the block accepts fields this cycle.
REQ-013 The port imem_we (output, 1 bit) SHALL be the instruction-memory write strobe.
REQ-014 The port imem_addr (output, 6 bits) SHALL be the word address of the write.
REQ-015 The port imem_wdata (output, 32 bits) SHALL be the encoded instruction word.
REQ-016 The port busy (output, 1 bit) SHALL indicate that a load is in progress.
REQ-017 The port done (output, 1 bit) SHALL indicate that the load is finished.
REQ-018 The port err (output, 1 bit) SHALL be a sticky error flag.
REQ-019 The port count (output, 7 bits) SHALL give the number of words written in the current load.

Function
REQ-020 The block SHALL implement an FSM with states IDLE, LOAD, WRITE and DONE.
REQ-021 In IDLE, start SHALL move the FSM to LOAD and clear count, err and the address pointer.
REQ-022 in_ready SHALL be 1 only in LOAD.
REQ-023 A transfer SHALL occur when in_valid and in_ready are both 1.
REQ-024 On a transfer with in_kind 0-6, the block SHALL register the encoded word and last, and move the FSM to WRITE.
REQ-025 In WRITE, imem_we SHALL be 1 for exactly one cycle, with imem_addr equal to the pointer and imem_wdata equal to the registered word; latency from transfer to write SHALL be 1 cycle.
REQ-026 After a write, the pointer and count SHALL increment.
REQ-027 After a write, the next state SHALL be DONE if last was set or count reaches 64, otherwise LOAD.
REQ-028 If count reaches 64 without last, err SHALL be set.
REQ-029 R-format encoding SHALL be opcode[31:21], Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0].
REQ-030 R-format opcodes SHALL be ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-031 D-format encoding SHALL be opcode[31:21], DT_address[20:12]=imm[8:0], op[11:10]=00, Rn[9:5], Rt[4:0].
REQ-032 D-format opcodes SHALL be LDUR 11111000010 and STUR 11111000000.
REQ-033 CBZ encoding SHALL be 10110100 in [31:24], imm[18:0] in [23:5], and Rt in [4:0].
REQ-034 Unused fields SHALL be ignored: imm for R-format, rm for D-format and CBZ, imm[18:9] for D-format, and rn for CBZ.
REQ-035 A transfer with in_kind=7 SHALL be accepted and dropped: err is set, no write occurs, count is unchanged, the FSM stays in LOAD, and last on that beat is ignored.
REQ-036 start SHALL be ignored in LOAD and WRITE.
REQ-037 In DONE, done SHALL be 1 and start SHALL restart a load as from IDLE; without start, DONE SHALL be held.
REQ-038 busy SHALL be 1 in LOAD and WRITE, and 0 otherwise.
REQ-039 err SHALL clear only on reset or on start.
REQ-040 imem_addr SHALL wrap modulo 64, although no write occurs beyond 64 per load.

Reset
REQ-041 While reset is asserted, the FSM SHALL enter IDLE, and in_ready, imem_we, imem_addr, imem_wdata, busy, done, err and count SHALL all be 0.
REQ-042 Reset asserted mid-write SHALL suppress imem_we in that cycle.
REQ-043 reset SHALL take priority over start and in_valid.

Verification
REQ-044 start, then ADD X1,X2,X3 with last -> imem_we at addr 0 with data 0x8B030041, then done=1 and count=1.
REQ-045 SUB X9,X10,X11, then LDUR X5,[X6,#8], then CBZ X7 with imm=3 and last -> writes 0xCB0B0149@0, 0xF84080C5@1, 0xB4000067@2; count=3.
REQ-046 STUR X0,[X1,#0], then in_kind=7, then ORR X2,X2,X0 with last -> writes 0xF8000020@0 and 0xAA000042@1; err=1; count=2.
REQ-047 64 valid words without last -> the final write is at addr 63, then done=1, err=1, count=64, and in_ready=0 afterwards.
REQ-048 reset asserted in the WRITE cycle -> no imem_we and all outputs 0 next cycle; a subsequent start restarts at addr 0.
REQ-049 start asserted during LOAD -> ignored: count and address are unchanged and err is unchanged.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Field/handshake bundle between a program source and the instruction encoder.
// The master side supplies decoded instruction fields; the slave side encodes
// them and reports the instruction-memory write strobe and load status.
interface instr_encoder_if;
    logic        start;
    logic        in_valid;
    logic [2:0]  in_kind;
    logic [4:0]  rd_rt;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [18:0] imm;
    logic        last;
    logic        in_ready;
    logic        imem_we;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [6:0]  count;

    modport master (
        output start, in_valid, in_kind, rd_rt, rn, rm, imm, last,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );

    modport slave (
        input  start, in_valid, in_kind, rd_rt, rn, rm, imm, last,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, err, count
    );
endinterface

// File: rtl/instr_encoder.sv
// LEGv8 instruction encoder: accepts decoded instruction fields one at a time
// and writes the 32-bit machine words into a 64-word instruction memory,
// starting at address 0 for each program load.
module instr_encoder (
    input  logic              clk,
    input  logic              reset,
    instr_encoder_if.slave    bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    logic [1:0]  r_state;
    logic [5:0]  r_ptr;
    logic [6:0]  r_count;
    logic        r_err;
    logic [31:0] r_word;
    logic        r_last;

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_xfer;
    logic        w_full;

    // A transfer only happens while loading; kind 7 is the single illegal code.
    assign w_xfer  = bus.in_valid && (r_state == ST_LOAD);
    assign w_legal = (bus.in_kind != 3'd7);
    // The write in progress is the 64th of this load.
    assign w_full  = (r_count == 7'd63);

    // Combinational field packing for each instruction format.
    always_comb begin
        w_word = 32'd0;
        case (bus.in_kind)
            3'd0:    w_word = {OPC_ADD,  bus.rm, 6'd0, bus.rn, bus.rd_rt};
            3'd1:    w_word = {OPC_SUB,  bus.rm, 6'd0, bus.rn, bus.rd_rt};
            3'd2:    w_word = {OPC_AND,  bus.rm, 6'd0, bus.rn, bus.rd_rt};
            3'd3:    w_word = {OPC_ORR,  bus.rm, 6'd0, bus.rn, bus.rd_rt};
            3'd4:    w_word = {OPC_LDUR, bus.imm[8:0], 2'b00, bus.rn, bus.rd_rt};
            3'd5:    w_word = {OPC_STUR, bus.imm[8:0], 2'b00, bus.rn, bus.rd_rt};
            3'd6:    w_word = {OPC_CBZ,  bus.imm, bus.rd_rt};
            default: w_word = 32'd0;
        endcase
    end

    // Load sequencing: capture a word, write it the next cycle, then either
    // return for more fields or finish when the program ends or memory fills.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= 6'd0;
            r_count <= 7'd0;
            r_err   <= 1'b0;
            r_word  <= 32'd0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state <= ST_LOAD;
                        r_ptr   <= 6'd0;
                        r_count <= 7'd0;
                        r_err   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        if (w_legal) begin
                            r_word  <= w_word;
                            r_last  <= bus.last;
                            r_state <= ST_WRITE;
                        end else begin
                            // Illegal beat is consumed but leaves no trace except err.
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_ptr   <= r_ptr + 6'd1;
                    r_count <= r_count + 7'd1;
                    if (r_last || w_full) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                    // Memory filled before the program said it was finished.
                    if (w_full && !r_last) begin
                        r_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Reset gates the strobes immediately so a write caught by reset never lands.
    assign bus.in_ready   = (r_state == ST_LOAD)  && !reset;
    assign bus.imem_we    = (r_state == ST_WRITE) && !reset;
    assign bus.imem_addr  = r_ptr;
    assign bus.imem_wdata = r_word;
    assign bus.busy       = (r_state == ST_LOAD) || (r_state == ST_WRITE);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.err        = r_err;
    assign bus.count      = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodes short programs and checks each
// instruction-memory write and the load status flags.
module tb_instr_encoder;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present one instruction for a single beat, then check the write that follows.
    task automatic send_write(input string tag, input logic [2:0] kind, input logic [4:0] rd,
                              input logic [4:0] rn_v, input logic [4:0] rm_v,
                              input logic [18:0] imm_v, input logic last_v,
                              input logic [5:0] exp_addr, input logic [31:0] exp_data);
        bus.in_kind  = kind;
        bus.rd_rt    = rd;
        bus.rn       = rn_v;
        bus.rm       = rm_v;
        bus.imm      = imm_v;
        bus.last     = last_v;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.last     = 1'b0;
        check({tag, "_we"},   32'(bus.imem_we),   32'd1);
        check({tag, "_addr"}, 32'(bus.imem_addr), 32'(exp_addr));
        check({tag, "_data"}, bus.imem_wdata,     exp_data);
        $display("write %s addr=%0d data=0x%08h", tag, bus.imem_addr, bus.imem_wdata);
        step();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_word;
        logic [4:0]  a_rd;
        logic [4:0]  a_rn;
        logic [4:0]  a_rm;

        checks   = 0;
        failures = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_kind  = 3'd0;
        bus.rd_rt    = 5'd0;
        bus.rn       = 5'd0;
        bus.rm       = 5'd0;
        bus.imm      = 19'd0;
        bus.last     = 1'b0;

        // Reset state, sampled with reset still asserted
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready),   32'd0);
        check("rst_we",       32'(bus.imem_we),    32'd0);
        check("rst_addr",     32'(bus.imem_addr),  32'd0);
        check("rst_wdata",    bus.imem_wdata,      32'd0);
        check("rst_busy",     32'(bus.busy),       32'd0);
        check("rst_done",     32'(bus.done),       32'd0);
        check("rst_err",      32'(bus.err),        32'd0);
        check("rst_count",    32'(bus.count),      32'd0);
        reset = 1'b0;
        step();
        check("idle_ready", 32'(bus.in_ready), 32'd0);

        // Program 1: ADD X1,X2,X3 with last
        do_start();
        check("p1_ready", 32'(bus.in_ready), 32'd1);
        check("p1_busy",  32'(bus.busy),     32'd1);
        send_write("p1_add", 3'd0, 5'd1, 5'd2, 5'd3, 19'h12345, 1'b1, 6'd0, 32'h8B030041);
        check("p1_done",  32'(bus.done),    32'd1);
        check("p1_count", 32'(bus.count),   32'd1);
        check("p1_busy0", 32'(bus.busy),    32'd0);
        check("p1_we0",   32'(bus.imem_we), 32'd0);
        $display("program1 done=%0d count=%0d", bus.done, bus.count);

        // Program 2: SUB, LDUR (junk in rm and imm[18:9]), CBZ (junk in rn, rm)
        do_start();
        check("p2_count0", 32'(bus.count), 32'd0);
        send_write("p2_sub",  3'd1, 5'd9, 5'd10, 5'd11, 19'h7FFFF, 1'b0, 6'd0, 32'hCB0B0149);
        send_write("p2_ldur", 3'd4, 5'd5, 5'd6,  5'd31, 19'h7FE08, 1'b0, 6'd1, 32'hF84080C5);
        send_write("p2_cbz",  3'd6, 5'd7, 5'd13, 5'd22, 19'd3,     1'b1, 6'd2, 32'hB4000067);
        check("p2_done",  32'(bus.done),  32'd1);
        check("p2_count", 32'(bus.count), 32'd3);
        check("p2_err",   32'(bus.err),   32'd0);

        // Program 3: STUR, illegal kind carrying last, ORR with last
        do_start();
        send_write("p3_stur", 3'd5, 5'd0, 5'd1, 5'd9, 19'd0, 1'b0, 6'd0, 32'hF8000020);
        bus.in_kind  = 3'd7;
        bus.last     = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.last     = 1'b0;
        check("p3_ill_we",    32'(bus.imem_we),  32'd0);
        check("p3_ill_ready", 32'(bus.in_ready), 32'd1);
        check("p3_ill_err",   32'(bus.err),      32'd1);
        check("p3_ill_count", 32'(bus.count),    32'd1);
        check("p3_ill_done",  32'(bus.done),     32'd0);
        $display("illegal beat err=%0d count=%0d", bus.err, bus.count);
        send_write("p3_orr", 3'd3, 5'd2, 5'd2, 5'd0, 19'h55, 1'b1, 6'd1, 32'hAA000042);
        check("p3_done",  32'(bus.done),  32'd1);
        check("p3_err",   32'(bus.err),   32'd1);
        check("p3_count", 32'(bus.count), 32'd2);

        // Program 4: 64 ADD words without last; start in LOAD is ignored; err clears on start
        do_start();
        check("p4_err_clr", 32'(bus.err), 32'd0);
        for (int i = 0; i < 64; i++) begin
            a_rd = 5'(i);
            a_rn = 5'(i + 7);
            a_rm = 5'(31 - i);
            exp_word = {11'b10001011000, a_rm, 6'd0, a_rn, a_rd};
            send_write($sformatf("p4_w%0d", i), 3'd0, a_rd, a_rn, a_rm, 19'd0, 1'b0, 6'(i), exp_word);
            if (i == 0) begin
                do_start();
                check("p4_start_ready", 32'(bus.in_ready), 32'd1);
                check("p4_start_count", 32'(bus.count),    32'd1);
                check("p4_start_addr",  32'(bus.imem_addr), 32'd1);
                check("p4_start_err",   32'(bus.err),      32'd0);
            end
        end
        check("p4_done",  32'(bus.done),      32'd1);
        check("p4_err",   32'(bus.err),       32'd1);
        check("p4_count", 32'(bus.count),     32'd64);
        check("p4_ready", 32'(bus.in_ready),  32'd0);
        check("p4_wrap",  32'(bus.imem_addr), 32'd0);
        step();
        check("p4_hold_done", 32'(bus.done), 32'd1);

        // Program 5: reset during the WRITE cycle, then a fresh load
        do_start();
        bus.in_kind  = 3'd0;
        bus.rd_rt    = 5'd4;
        bus.rn       = 5'd5;
        bus.rm       = 5'd6;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("p5_rst_we", 32'(bus.imem_we), 32'd0);
        step();
        check("p5_we",    32'(bus.imem_we),   32'd0);
        check("p5_addr",  32'(bus.imem_addr), 32'd0);
        check("p5_wdata", bus.imem_wdata,     32'd0);
        check("p5_busy",  32'(bus.busy),      32'd0);
        check("p5_count", 32'(bus.count),     32'd0);
        check("p5_ready", 32'(bus.in_ready),  32'd0);
        reset = 1'b0;
        step();
        do_start();
        send_write("p5_add", 3'd0, 5'd1, 5'd2, 5'd3, 19'd0, 1'b1, 6'd0, 32'h8B030041);
        check("p5_done", 32'(bus.done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
